// File: rtl/seq_scan_arbiter.sv
// seq_scan_arbiter: round-robin arbiter that lends one Moore serial pattern
// detector to NREQ requesters. The winning requester's WIDTH-bit word is shifted
// MSB-first into the detector, matches are counted, and a per-job result is
// reported through done / done_id / match_cnt.
module seq_scan_arbiter #(
    parameter  int              NREQ    = 4,
    parameter  int              WIDTH   = 8,
    parameter  int              PLEN    = 5,
    parameter  logic [PLEN-1:0] PATTERN = 5'b11101,
    parameter  bit              OVERLAP = 1'b1,
    localparam int              IDW     = $clog2(NREQ),
    localparam int              CW      = $clog2(WIDTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] data,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic                  serial_bit,
    output logic                  hit,
    output logic                  done,
    output logic [IDW-1:0]        done_id,
    output logic [CW-1:0]         match_cnt
);

    localparam int BW = $clog2(WIDTH);
    localparam int VW = $clog2(PLEN + 1);
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_REPORT
    } state_t;

    state_t          r_state;
    logic [IDW-1:0]  r_rr_ptr;
    logic [IDW-1:0]  r_winner;
    logic [WIDTH-1:0] r_shreg;
    logic [PLEN-2:0] r_hist;
    logic [VW-1:0]   r_valid;
    logic [BW-1:0]   r_bit_cnt;
    logic [CW-1:0]   r_cnt;
    logic [NREQ-1:0] r_grant;
    logic            r_done;
    logic [IDW-1:0]  r_done_id;
    logic [CW-1:0]   r_match_cnt;

    logic            w_found;
    logic [IDW-1:0]  w_pick;
    logic            w_bit;
    logic [PLEN-1:0] w_cand;
    logic            w_match;
    logic            w_last;

    // Rotating-priority search: first set request at or after r_rr_ptr, with wrap.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req[IDW'((int'(r_rr_ptr) + k) % NREQ)]) begin
                w_found = 1'b1;
                w_pick  = IDW'((int'(r_rr_ptr) + k) % NREQ);
            end
        end
    end

    // Detector view of the current bit; a match needs PLEN valid bits including this one.
    always_comb begin
        w_bit   = r_shreg[WIDTH-1];
        w_cand  = {r_hist, w_bit};
        w_match = (r_state == S_SHIFT) && (r_valid >= VW'(PLEN - 1)) && (w_cand == PATTERN);
        w_last  = (r_bit_cnt == BW'(WIDTH - 1));
    end

    // Arbiter / shifter / detector FSM with registered grant and result outputs.
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_winner    <= '0;
            r_shreg     <= '0;
            r_hist      <= '0;
            r_valid     <= '0;
            r_bit_cnt   <= '0;
            r_cnt       <= '0;
            r_grant     <= '0;
            r_done      <= 1'b0;
            r_done_id   <= '0;
            r_match_cnt <= '0;
        end else begin
            r_grant <= '0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_winner <= w_pick;
                        r_grant  <= ONE_HOT0 << w_pick;
                        r_state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_shreg   <= data[r_winner*WIDTH +: WIDTH];
                    r_hist    <= '0;
                    r_valid   <= '0;
                    r_bit_cnt <= '0;
                    r_cnt     <= '0;
                    r_rr_ptr  <= (r_winner == IDW'(NREQ - 1)) ? '0 : r_winner + IDW'(1);
                    r_state   <= S_SHIFT;
                end
                S_SHIFT: begin
                    // Zero fill leaves the register clear once the word is consumed,
                    // so serial_bit reads 0 outside SHIFT without extra gating.
                    r_shreg   <= {r_shreg[WIDTH-2:0], 1'b0};
                    r_hist    <= w_cand[PLEN-2:0];
                    r_bit_cnt <= r_bit_cnt + BW'(1);
                    if (w_match && (OVERLAP == 1'b0)) begin
                        r_valid <= '0;
                    end else if (r_valid < VW'(PLEN)) begin
                        r_valid <= r_valid + VW'(1);
                    end
                    if (w_match) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                    if (w_last) begin
                        r_done      <= 1'b1;
                        r_done_id   <= r_winner;
                        r_match_cnt <= r_cnt + CW'(w_match);
                        r_state     <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign grant      = r_grant;
    assign busy       = (r_state != S_IDLE);
    assign serial_bit = r_shreg[WIDTH-1];
    assign hit        = w_match;
    assign done       = r_done;
    assign done_id    = r_done_id;
    assign match_cnt  = r_match_cnt;

endmodule
